// File: rtl/multiplier_iterative.sv
// -----------------------------------------------------------------------------
// multiplier_iterative
//   Iterative shift-add multiplier. The controller, the iteration counter and
//   the datapath are all in this one block. It produces a WIDTH x WIDTH ->
//   2*WIDTH product and handles one partial product per clock. The operands
//   are signed or unsigned, chosen for each operation. When EARLY_EXIT is set,
//   the block can finish early once no multiplier bits remain. The product is
//   held until the consumer acknowledges it.
//
// Parameters
//   WIDTH        operand width in bits (>= 2); the result is 2*WIDTH bits
//   EARLY_EXIT   1: finish as soon as the remaining multiplier bits are zero
//
// Ports
//   clock         rising-edge clock
//   n_reset       asynchronous, active-low reset
//   start         request; accepted only while ready=1
//   signed_mode   1: two's-complement operands; sampled with start
//   multiplicand  operand A; sampled with start
//   multiplier    operand B; sampled with start
//   ack           consumer has taken the result; honoured only while done=1
//   abort         synchronous cancel; takes effect from any state
//   ready         idle; a start can be accepted
//   busy          iterating
//   done          result valid and held
//   result        product; valid while done=1, otherwise holds the last value
// -----------------------------------------------------------------------------
module multiplier_iterative #(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b0
) (
  input  logic                 clock,
  input  logic                 n_reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  input  logic                 ack,
  input  logic                 abort,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_reg;
  logic            ready_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [PW-1:0]   a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [PW-1:0]   acc_reg;
  logic [CW-1:0]   cnt_reg;
  logic            sgn_reg;
  logic [PW-1:0]   result_reg;

  // Datapath values for the next edge
  logic [PW-1:0]    a_load_next;
  logic [PW-1:0]    acc_next;
  logic [PW-1:0]    a_next;
  logic [WIDTH-1:0] b_next;
  logic [CW-1:0]    cnt_next;
  logic             last_iter;
  logic             sub_step;
  logic             rem_zero;
  logic             finish;

  // The sign bit fills the upper half only for signed operations.
  // Otherwise the upper half is zero.
  logic [WIDTH-1:0] ext_bits;
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_ext
      assign ext_bits[gi] = signed_mode & multiplicand[WIDTH-1];
    end
  endgenerate

  always_comb begin
    a_load_next = {ext_bits, multiplicand};
    last_iter   = (cnt_reg == CNT_ONE);
    // In two's complement the MSB of a signed multiplier has negative weight.
    // So the final partial product is subtracted, not added.
    sub_step    = sgn_reg & last_iter;
    acc_next    = acc_reg;
    if (b_reg[0]) begin
      if (sub_step) begin
        acc_next = acc_reg - a_reg;
      end else begin
        acc_next = acc_reg + a_reg;
      end
    end
    a_next   = a_reg << 1;
    b_next   = b_reg >> 1;
    cnt_next = cnt_reg - CNT_ONE;
    // A negative signed multiplier keeps its MSB set in b_reg until the last
    // step. So early exit never fires for it.
    rem_zero = (b_next == '0);
    finish   = last_iter | (EARLY_EXIT & rem_zero);
  end

  // The controller and the datapath share one sequential block.
  // ready, busy and done are registered, and they always match state_reg.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_reg  <= S_IDLE;
      ready_reg  <= 1'b1;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      sgn_reg    <= 1'b0;
      result_reg <= '0;
    end else if (abort) begin
      // Cancel from any state. The last completed result is kept.
      state_reg <= S_IDLE;
      ready_reg <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_reg     <= a_load_next;
            b_reg     <= multiplier;
            acc_reg   <= '0;
            cnt_reg   <= CNT_INIT;
            sgn_reg   <= signed_mode;
            state_reg <= S_BUSY;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
          end
        end
        S_BUSY: begin
          acc_reg <= acc_next;
          a_reg   <= a_next;
          b_reg   <= b_next;
          cnt_reg <= cnt_next;
          if (finish) begin
            result_reg <= acc_next;
            state_reg  <= S_DONE;
            ready_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
          end
        end
        S_DONE: begin
          // In this state start is ignored, even when it comes with ack.
          if (ack) begin
            state_reg <= S_IDLE;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          ready_reg <= 1'b1;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign ready  = ready_reg;
  assign busy   = busy_reg;
  assign done   = done_reg;
  assign result = result_reg;

endmodule

// File: tb/tb_multiplier_iterative.sv
module tb_multiplier_iterative;

  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        abort = 1'b0;
  logic [1:0]  start_v = '0;
  logic [1:0]  ack_v = '0;
  logic [1:0]  ready_v;
  logic [1:0]  busy_v;
  logic [1:0]  done_v;
  logic [15:0] result_v [2];

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  // DUT 0: full-length iteration
  multiplier_iterative #(.WIDTH(8), .EARLY_EXIT(1'b0)) u_dut0 (
    .clock(clock), .n_reset(n_reset), .start(start_v[0]),
    .signed_mode(signed_mode), .multiplicand(multiplicand), .multiplier(multiplier),
    .ack(ack_v[0]), .abort(abort),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]), .result(result_v[0])
  );

  // DUT 1: early exit enabled
  multiplier_iterative #(.WIDTH(8), .EARLY_EXIT(1'b1)) u_dut1 (
    .clock(clock), .n_reset(n_reset), .start(start_v[1]),
    .signed_mode(signed_mode), .multiplicand(multiplicand), .multiplier(multiplier),
    .ack(ack_v[1]), .abort(abort),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]), .result(result_v[1])
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle start pulse at a negedge. The task returns at the first
  // negedge after the accept edge, and then it scrambles the operands.
  task automatic start_op(input int which, input bit sm, input logic [7:0] a, input logic [7:0] b);
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    start_v[which] = 1'b1;
    @(negedge clock);
    start_v[which] = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    signed_mode  = ~sm;
  endtask

  // Count busy cycles until done is seen. The wait is bounded.
  task automatic wait_done(input int which, output int cycles);
    cycles = 0;
    for (int i = 0; i < 40 && !done_v[which]; i++) begin
      if (busy_v[which]) cycles++;
      @(negedge clock);
    end
    check_val("done_timeout", {31'd0, done_v[which]}, 32'd1);
  endtask

  task automatic ack_op(input int which);
    ack_v[which] = 1'b1;
    @(negedge clock);
    ack_v[which] = 1'b0;
    check_val("ack_ready", {31'd0, ready_v[which]}, 32'd1);
    check_val("ack_done", {31'd0, done_v[which]}, 32'd0);
  endtask

  task automatic run_op(input int which, input bit sm, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp, input int exp_cyc, input string tag);
    int cyc;
    start_op(which, sm, a, b);
    wait_done(which, cyc);
    $display("op %s dut=%0d sm=%0d a=%h b=%h result=%h cycles=%0d", tag, which, sm, a, b,
             result_v[which], cyc);
    check_val({tag, "_result"}, {16'd0, result_v[which]}, {16'd0, exp});
    check_val({tag, "_cycles"}, cyc, exp_cyc);
    ack_op(which);
  endtask

  initial begin
    int cyc;
    logic [15:0] held;
    bit seen_done;

    // 1: reset held low while start toggles
    repeat (2) begin
      @(negedge clock);
      start_v = ~start_v;
    end
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check_val("rst_ready", {31'd0, ready_v[d]}, 32'd1);
      check_val("rst_busy", {31'd0, busy_v[d]}, 32'd0);
      check_val("rst_done", {31'd0, done_v[d]}, 32'd0);
      check_val("rst_result", {16'd0, result_v[d]}, 32'd0);
    end
    start_v = '0;
    n_reset = 1'b1;
    repeat (2) @(negedge clock);
    check_val("post_rst_ready", {30'd0, ready_v}, 32'd3);
    check_val("post_rst_busy", {30'd0, busy_v}, 32'd0);
    $display("reset checked");

    // 2: unsigned multiplies, full length
    run_op(0, 1'b0, 8'd200, 8'd150, 16'h7530, 8, "u200x150");
    run_op(0, 1'b0, 8'hFF, 8'hFF, 16'hFE01, 8, "u255x255");

    // 3: signed and unsigned treatment of the same operands
    run_op(0, 1'b1, 8'hFD, 8'h05, 16'hFFF1, 8, "sFDx05");
    run_op(0, 1'b0, 8'hFD, 8'h05, 16'h04F1, 8, "uFDx05");
    run_op(0, 1'b1, 8'h80, 8'h80, 16'h4000, 8, "s80x80");

    // 4: early exit
    run_op(1, 1'b0, 8'd100, 8'd3, 16'h012C, 2, "ee100x3");
    run_op(1, 1'b0, 8'd77, 8'd0, 16'h0000, 1, "ee77x0");
    run_op(1, 1'b1, 8'd3, 8'hFF, 16'hFFFD, 8, "ee3xm1");
    run_op(1, 1'b0, 8'd5, 8'h40, 16'h0140, 7, "ee5x64");

    // 5: handshake. ack is withheld, start comes in DONE, then start and ack together
    start_op(0, 1'b0, 8'd200, 8'd150);
    wait_done(0, cyc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      check_val("hold_done", {31'd0, done_v[0]}, 32'd1);
      check_val("hold_result", {16'd0, result_v[0]}, 32'h7530);
    end
    signed_mode = 1'b0; multiplicand = 8'd1; multiplier = 8'd1;
    start_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    check_val("start_in_done", {30'd0, done_v[0], busy_v[0]}, 32'd2);
    start_v[0] = 1'b1;
    ack_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    ack_v[0] = 1'b0;
    check_val("start_ack_ready", {31'd0, ready_v[0]}, 32'd1);
    check_val("start_ack_busy", {31'd0, busy_v[0]}, 32'd0);
    check_val("start_ack_result", {16'd0, result_v[0]}, 32'h7530);
    @(negedge clock);
    check_val("no_queue", {31'd0, ready_v[0]}, 32'd1);
    $display("op hold/start+ack dut=0 result=%h", result_v[0]);

    // ack while IDLE
    ack_v[0] = 1'b1;
    @(negedge clock);
    ack_v[0] = 1'b0;
    check_val("ack_idle", {30'd0, ready_v[0], done_v[0]}, 32'd2);

    // start and ack while BUSY are both ignored
    start_op(0, 1'b0, 8'hFF, 8'hFF);
    multiplicand = 8'd2; multiplier = 8'd2;
    start_v[0] = 1'b1;
    ack_v[0] = 1'b1;
    @(negedge clock);
    start_v[0] = 1'b0;
    ack_v[0] = 1'b0;
    wait_done(0, cyc);
    check_val("busy_ign_result", {16'd0, result_v[0]}, 32'hFE01);
    check_val("busy_ign_cycles", cyc + 1, 8);
    $display("op busy-ignore dut=0 result=%h cycles=%0d", result_v[0], cyc + 1);
    ack_op(0);

    // 6: abort in the third BUSY cycle
    held = 16'hFE01;
    start_op(0, 1'b0, 8'd12, 8'd12);
    check_val("abort_b1", {31'd0, busy_v[0]}, 32'd1);
    @(negedge clock);
    @(negedge clock);
    check_val("abort_b3", {31'd0, busy_v[0]}, 32'd1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check_val("abort_ready", {31'd0, ready_v[0]}, 32'd1);
    check_val("abort_busy", {31'd0, busy_v[0]}, 32'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done_v[0]) seen_done = 1'b1;
    end
    check_val("abort_no_done", {31'd0, seen_done}, 32'd0);
    check_val("abort_result", {16'd0, result_v[0]}, {16'd0, held});
    $display("op abort dut=0 result=%h", result_v[0]);

    // reset pulled low during BUSY
    start_op(0, 1'b0, 8'd9, 8'd9);
    @(negedge clock);
    #2 n_reset = 1'b0;
    #1;
    check_val("mid_rst_ready", {31'd0, ready_v[0]}, 32'd1);
    check_val("mid_rst_busy", {31'd0, busy_v[0]}, 32'd0);
    check_val("mid_rst_done", {31'd0, done_v[0]}, 32'd0);
    check_val("mid_rst_result", {16'd0, result_v[0]}, 32'd0);
    @(negedge clock);
    n_reset = 1'b1;
    $display("op mid-reset dut=0 result=%h", result_v[0]);
    @(negedge clock);
    run_op(0, 1'b0, 8'd9, 8'd9, 16'h0051, 8, "u9x9");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
